id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the five-stage miniLA pipeline, directly upstream of the ALU. Each cycle it registers one decoded instruction from ID (instruction word, PC, register operands, immediates, `alu_op`, `alu_sel`, write-back control) and presents it to the ALU for the whole EX cycle. On capture it resolves RAW hazards by forwarding from EX, MEM and WB. It detects load-use hazards, inserts bubbles for them, and supports stall and branch flush.

## Interface
- `WIDTH`, 32: datapath width.
- `REGW`, 5: register index width.
- `cpu_clk  in  1`: clock; all state updates on the rising edge.
- `cpu_rstn  in  1`: reset. Asynchronous and active-low.
- `stall  in  1`: global pipeline freeze from the downstream memory stage.
- `flush  in  1`: taken-branch kill from EX; the instruction entering from ID is wrong-path.
- `id_valid  in  1`: ID holds a real instruction.
- `id_inst, id_pc, id_rD1, id_rD2, id_sext1, id_zext  in  32 each`: decoded fields.
- `id_rR1, id_rR2  in  5`: source register indices.
- `id_use_r1, id_use_r2  in  1`: the instruction reads that source.
- `id_alu_op  in  4`, `id_alu_sel  in  3`: ALU control.
- `id_rf_we  in  1`, `id_wR  in  5`, `id_is_load  in  1`: write-back control.
- `ex_alu_c  in  32`: ALU result of the instruction currently held in this stage (EX forward source).
- `mem_rf_we  in  1`, `mem_wR  in  5`, `mem_wD  in  32`: MEM-stage producer.
- `wb_rf_we  in  1`, `wb_wR  in  5`, `wb_wD  in  32`: WB-stage producer.
- `ex_valid  out  1`, `ex_inst, ex_pc, ex_rD1, ex_rD2, ex_sext1, ex_zext  out  32`, `ex_alu_op  out  4`, `ex_alu_sel  out  3`, `ex_rf_we  out  1`, `ex_wR  out  5`, `ex_is_load  out  1`: registered EX-stage fields.
- `load_use_stall  out  1`: combinational; tells PC and IF/ID to hold.
- `bubble_cnt  out  16`: count of bubbles inserted.

## Operation
- **Reset.** While `cpu_rstn`=0, every registered output is 0, including `ex_valid`, `ex_rf_we`, `ex_is_load` and `bubble_cnt`. This is a bubble.
- **Priority each edge:** stall > flush > load-use bubble > normal capture.
- **stall=1.** All registers hold. `flush` is ignored, because the branch stays in EX and the branch unit re-asserts `flush`. `bubble_cnt` holds.
- **flush=1 (no stall).** Load a bubble: `ex_valid`=0, `ex_rf_we`=0, `ex_is_load`=0, other fields don't-care (implementation loads 0). Increment `bubble_cnt`.
- **Load-use condition.** `load_use_stall` = `id_valid` & `ex_valid` & `ex_is_load` & `ex_rf_we` & (`ex_wR`≠0) & ((`id_use_r1` & `id_rR1`==`ex_wR`) | (`id_use_r2` & `id_rR2`==`ex_wR`)) & ~`flush` & ~`stall`.
  - When the condition holds, load a bubble as for flush and increment `bubble_cnt`. ID holds externally, so the same instruction is re-presented next cycle.
- **Normal capture.** Register all `id_*` fields, with `ex_valid` taking `id_valid`. `id_valid`=0 is captured as a bubble with `ex_rf_we`=0 and does not count toward `bubble_cnt`.
- **Forwarding per source n∈{1,2}.** Applied to the value captured into `ex_rDn`, first match wins:
  - EX: `ex_valid` & `ex_rf_we` & ~`ex_is_load` & `ex_wR`==`id_rRn` gives `ex_alu_c`;
  - else MEM: `mem_rf_we` & `mem_wR`==`id_rRn` gives `mem_wD`;
  - else WB: `wb_rf_we` & `wb_wR`==`id_rRn` gives `wb_wD`;
  - else `id_rDn`.
- **Register 0.** Forwarding never applies when `id_rRn`==0.
- **Unused sources.** Forwarding is applied regardless of `id_use_rn`; it is harmless.
- **bubble_cnt.** Saturates at 16'hFFFF and does not wrap.
- `flush` and a load-use bubble are mutually exclusive in practice (a branch is not a load). Flush still masks `load_use_stall`.

## Timing
- One-cycle latency: ID fields sampled at edge k appear on the `ex_*` outputs after edge k and stay stable until edge k+1.
- `load_use_stall` is purely combinational from current inputs and state, so it is valid in the same cycle.
- A load followed immediately by a dependent instruction gives exactly one bubble. The dependent instruction then captures the load data via MEM forwarding.
- Asynchronous reset mid-operation clears state immediately, regardless of the clock. The first capture happens at the first rising edge after `cpu_rstn` rises.

## Test plan
- **Reset.** Hold `cpu_rstn`=0 with random inputs → all outputs 0, `bubble_cnt`=0. Release and present `id_valid`=1, `id_pc`=0x1C000000 → after one edge `ex_pc`=0x1C000000, `ex_valid`=1.
- **EX forward.** `ex` holds an add writing r5 with `ex_alu_c`=0x00000030; ID instruction has `id_rR1`=5, `id_rD1`=0x11 → `ex_rD1`=0x30. With the same r5 also in MEM (`mem_wD`=0x99), EX still wins.
- **Load-use.** `ex` holds ld.w writing r7; ID uses `id_rR2`=7 → `load_use_stall`=1, next `ex_valid`=0, `bubble_cnt`=1. Next cycle `mem_wR`=7, `mem_wD`=0xDEADBEEF → `ex_rD2`=0xDEADBEEF, `load_use_stall`=0.
- **r0.** `id_rR1`=0 with `mem_rf_we`=1, `mem_wR`=0, `mem_wD`=0x5 → `ex_rD1`=`id_rD1`=0.
- **Stall vs flush.** `stall`=1 and `flush`=1 for 3 cycles → outputs unchanged, `bubble_cnt` unchanged. Then `stall`=0 with `flush`=1 → bubble, `bubble_cnt`+1.
- **Saturation.** Force 65537 flush cycles → `bubble_cnt`=0xFFFF and stays there.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the miniLA five-stage pipeline.
// It captures one decoded instruction per cycle, forwards operands from
// EX/MEM/WB on capture, and inserts bubbles on load-use hazards and flushes.
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             cpu_clk,
  input  logic             cpu_rstn,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_inst,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [WIDTH-1:0] id_rD1,
  input  logic [WIDTH-1:0] id_rD2,
  input  logic [WIDTH-1:0] id_sext1,
  input  logic [WIDTH-1:0] id_zext,
  input  logic [REGW-1:0]  id_rR1,
  input  logic [REGW-1:0]  id_rR2,
  input  logic             id_use_r1,
  input  logic             id_use_r2,
  input  logic [3:0]       id_alu_op,
  input  logic [2:0]       id_alu_sel,
  input  logic             id_rf_we,
  input  logic [REGW-1:0]  id_wR,
  input  logic             id_is_load,
  input  logic [WIDTH-1:0] ex_alu_c,
  input  logic             mem_rf_we,
  input  logic [REGW-1:0]  mem_wR,
  input  logic [WIDTH-1:0] mem_wD,
  input  logic             wb_rf_we,
  input  logic [REGW-1:0]  wb_wR,
  input  logic [WIDTH-1:0] wb_wD,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_inst,
  output logic [WIDTH-1:0] ex_pc,
  output logic [WIDTH-1:0] ex_rD1,
  output logic [WIDTH-1:0] ex_rD2,
  output logic [WIDTH-1:0] ex_sext1,
  output logic [WIDTH-1:0] ex_zext,
  output logic [3:0]       ex_alu_op,
  output logic [2:0]       ex_alu_sel,
  output logic             ex_rf_we,
  output logic [REGW-1:0]  ex_wR,
  output logic             ex_is_load,
  output logic             load_use_stall,
  output logic [15:0]      bubble_cnt
);

  logic             r_valid;
  logic [WIDTH-1:0] r_inst, r_pc, r_rD1, r_rD2, r_sext1, r_zext;
  logic [3:0]       r_alu_op;
  logic [2:0]       r_alu_sel;
  logic             r_rf_we;
  logic [REGW-1:0]  r_wR;
  logic             r_is_load;
  logic [15:0]      r_bubble_cnt;

  logic             w_ex_fwd_ok;
  logic             w_load_use;
  logic [WIDTH-1:0] w_fwd1, w_fwd2;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A load's result is not available in EX, so only non-load producers forward from EX.
  assign w_ex_fwd_ok = r_valid & r_rf_we & ~r_is_load;

  // Load-use hazard: the instruction in ID needs a value the load in EX has not produced yet.
  assign w_load_use = id_valid & r_valid & r_is_load & r_rf_we & (r_wR != '0) &
                      ((id_use_r1 & (id_rR1 == r_wR)) | (id_use_r2 & (id_rR2 == r_wR))) &
                      ~flush & ~stall;

  // Source 1 operand select: youngest producer wins, r0 never forwarded.
  always_comb begin
    w_fwd1 = id_rD1;
    if (id_rR1 != '0) begin
      if (w_ex_fwd_ok && (r_wR == id_rR1))     w_fwd1 = ex_alu_c;
      else if (mem_rf_we && (mem_wR == id_rR1)) w_fwd1 = mem_wD;
      else if (wb_rf_we && (wb_wR == id_rR1))   w_fwd1 = wb_wD;
    end
  end

  // Source 2 operand select: youngest producer wins, r0 never forwarded.
  always_comb begin
    w_fwd2 = id_rD2;
    if (id_rR2 != '0) begin
      if (w_ex_fwd_ok && (r_wR == id_rR2))     w_fwd2 = ex_alu_c;
      else if (mem_rf_we && (mem_wR == id_rR2)) w_fwd2 = mem_wD;
      else if (wb_rf_we && (wb_wR == id_rR2))   w_fwd2 = wb_wD;
    end
  end

  // Pipeline register: stall holds everything, flush/load-use load a counted bubble.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_valid      <= 1'b0;
      r_inst       <= '0;
      r_pc         <= '0;
      r_rD1        <= '0;
      r_rD2        <= '0;
      r_sext1      <= '0;
      r_zext       <= '0;
      r_alu_op     <= '0;
      r_alu_sel    <= '0;
      r_rf_we      <= 1'b0;
      r_wR         <= '0;
      r_is_load    <= 1'b0;
      r_bubble_cnt <= '0;
    end else if (!stall) begin
      if (flush || w_load_use) begin
        r_valid      <= 1'b0;
        r_inst       <= '0;
        r_pc         <= '0;
        r_rD1        <= '0;
        r_rD2        <= '0;
        r_sext1      <= '0;
        r_zext       <= '0;
        r_alu_op     <= '0;
        r_alu_sel    <= '0;
        r_rf_we      <= 1'b0;
        r_wR         <= '0;
        r_is_load    <= 1'b0;
        r_bubble_cnt <= sat_inc(r_bubble_cnt);
      end else begin
        r_valid      <= id_valid;
        r_inst       <= id_inst;
        r_pc         <= id_pc;
        r_rD1        <= w_fwd1;
        r_rD2        <= w_fwd2;
        r_sext1      <= id_sext1;
        r_zext       <= id_zext;
        r_alu_op     <= id_alu_op;
        r_alu_sel    <= id_alu_sel;
        r_rf_we      <= id_rf_we & id_valid;
        r_wR         <= id_wR;
        r_is_load    <= id_is_load & id_valid;
      end
    end
  end

  assign ex_valid       = r_valid;
  assign ex_inst        = r_inst;
  assign ex_pc          = r_pc;
  assign ex_rD1         = r_rD1;
  assign ex_rD2         = r_rD2;
  assign ex_sext1       = r_sext1;
  assign ex_zext        = r_zext;
  assign ex_alu_op      = r_alu_op;
  assign ex_alu_sel     = r_alu_sel;
  assign ex_rf_we       = r_rf_we;
  assign ex_wR          = r_wR;
  assign ex_is_load     = r_is_load;
  assign load_use_stall = w_load_use;
  assign bubble_cnt     = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the ID/EX register.
module tb_id_ex_stage;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn;
  logic        stall, flush, id_valid;
  logic [31:0] id_inst, id_pc, id_rD1, id_rD2, id_sext1, id_zext;
  logic [4:0]  id_rR1, id_rR2, id_wR, mem_wR, wb_wR;
  logic        id_use_r1, id_use_r2, id_rf_we, id_is_load;
  logic [3:0]  id_alu_op;
  logic [2:0]  id_alu_sel;
  logic [31:0] ex_alu_c, mem_wD, wb_wD;
  logic        mem_rf_we, wb_rf_we;

  logic        ex_valid, ex_rf_we, ex_is_load, load_use_stall;
  logic [31:0] ex_inst, ex_pc, ex_rD1, ex_rD2, ex_sext1, ex_zext;
  logic [3:0]  ex_alu_op;
  logic [2:0]  ex_alu_sel;
  logic [4:0]  ex_wR;
  logic [15:0] bubble_cnt;

  // Reference model state: what the EX stage should hold.
  logic        m_valid, m_rf_we, m_is_load;
  logic [31:0] m_inst, m_pc, m_rD1, m_rD2, m_sext1, m_zext;
  logic [3:0]  m_alu_op;
  logic [2:0]  m_alu_sel;
  logic [4:0]  m_wR;
  int unsigned m_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 cpu_clk = ~cpu_clk;

  id_ex_stage #(.WIDTH(32), .REGW(5)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_rD1(id_rD1),
    .id_rD2(id_rD2), .id_sext1(id_sext1), .id_zext(id_zext), .id_rR1(id_rR1),
    .id_rR2(id_rR2), .id_use_r1(id_use_r1), .id_use_r2(id_use_r2),
    .id_alu_op(id_alu_op), .id_alu_sel(id_alu_sel), .id_rf_we(id_rf_we),
    .id_wR(id_wR), .id_is_load(id_is_load), .ex_alu_c(ex_alu_c),
    .mem_rf_we(mem_rf_we), .mem_wR(mem_wR), .mem_wD(mem_wD),
    .wb_rf_we(wb_rf_we), .wb_wR(wb_wR), .wb_wD(wb_wD),
    .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_pc(ex_pc), .ex_rD1(ex_rD1),
    .ex_rD2(ex_rD2), .ex_sext1(ex_sext1), .ex_zext(ex_zext),
    .ex_alu_op(ex_alu_op), .ex_alu_sel(ex_alu_sel), .ex_rf_we(ex_rf_we),
    .ex_wR(ex_wR), .ex_is_load(ex_is_load), .load_use_stall(load_use_stall),
    .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ex_valid", ex_valid, m_valid);
    chk("ex_inst", ex_inst, m_inst);
    chk("ex_pc", ex_pc, m_pc);
    chk("ex_rD1", ex_rD1, m_rD1);
    chk("ex_rD2", ex_rD2, m_rD2);
    chk("ex_sext1", ex_sext1, m_sext1);
    chk("ex_zext", ex_zext, m_zext);
    chk("ex_alu_op", ex_alu_op, m_alu_op);
    chk("ex_alu_sel", ex_alu_sel, m_alu_sel);
    chk("ex_rf_we", ex_rf_we, m_rf_we);
    chk("ex_wR", ex_wR, m_wR);
    chk("ex_is_load", ex_is_load, m_is_load);
    chk("bubble_cnt", bubble_cnt, m_cnt[15:0]);
  endtask

  task automatic model_bubble();
    m_valid = 0; m_inst = 0; m_pc = 0; m_rD1 = 0; m_rD2 = 0; m_sext1 = 0;
    m_zext = 0; m_alu_op = 0; m_alu_sel = 0; m_rf_we = 0; m_wR = 0; m_is_load = 0;
  endtask

  // Operand the instruction should see: nearest older writer of that register.
  function automatic logic [31:0] m_operand(input logic [4:0] rr, input logic [31:0] rd);
    if (rr == 0) return rd;
    if (m_valid && m_rf_we && !m_is_load && m_wR == rr) return ex_alu_c;
    if (mem_rf_we && mem_wR == rr) return mem_wD;
    if (wb_rf_we && wb_wR == rr) return wb_wD;
    return rd;
  endfunction

  function automatic logic model_lus();
    logic dep;
    dep = (id_use_r1 && id_rR1 == m_wR) || (id_use_r2 && id_rR2 == m_wR);
    return id_valid && m_valid && m_is_load && m_rf_we && (m_wR != 0) && dep && !flush && !stall;
  endfunction

  task automatic model_edge(input logic lu);
    logic [31:0] op1, op2;
    if (stall) return;
    if (flush || lu) begin
      model_bubble();
      m_cnt = (m_cnt >= 32'hFFFF) ? 32'hFFFF : m_cnt + 1;
      return;
    end
    op1 = m_operand(id_rR1, id_rD1);
    op2 = m_operand(id_rR2, id_rD2);
    m_valid = id_valid; m_inst = id_inst; m_pc = id_pc; m_rD1 = op1; m_rD2 = op2;
    m_sext1 = id_sext1; m_zext = id_zext; m_alu_op = id_alu_op; m_alu_sel = id_alu_sel;
    m_rf_we = id_rf_we & id_valid; m_wR = id_wR; m_is_load = id_is_load & id_valid;
  endtask

  // Inputs are already driven (after a negedge); check, clock, check, return at next negedge.
  task automatic step(input bit chk_en);
    logic lu;
    #1;
    lu = model_lus();
    if (chk_en) chk("load_use_stall", load_use_stall, lu);
    model_edge(lu);
    @(posedge cpu_clk);
    #1;
    if (chk_en) check_all();
    @(negedge cpu_clk);
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; id_valid = 0; id_inst = 0; id_pc = 0; id_rD1 = 0; id_rD2 = 0;
    id_sext1 = 0; id_zext = 0; id_rR1 = 0; id_rR2 = 0; id_use_r1 = 0; id_use_r2 = 0;
    id_alu_op = 0; id_alu_sel = 0; id_rf_we = 0; id_wR = 0; id_is_load = 0;
    ex_alu_c = 0; mem_rf_we = 0; mem_wR = 0; mem_wD = 0; wb_rf_we = 0; wb_wR = 0; wb_wD = 0;
  endtask

  task automatic random_inputs();
    stall = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 7) == 0);
    id_valid = ($urandom_range(0, 5) != 0);
    id_inst = $urandom; id_pc = $urandom; id_rD1 = $urandom; id_rD2 = $urandom;
    id_sext1 = $urandom; id_zext = $urandom;
    id_rR1 = 5'($urandom_range(0, 7)); id_rR2 = 5'($urandom_range(0, 7));
    id_use_r1 = 1'($urandom); id_use_r2 = 1'($urandom);
    id_alu_op = 4'($urandom); id_alu_sel = 3'($urandom);
    id_rf_we = ($urandom_range(0, 3) != 0); id_wR = 5'($urandom_range(0, 7));
    id_is_load = ($urandom_range(0, 2) == 0);
    ex_alu_c = $urandom; mem_rf_we = 1'($urandom); mem_wR = 5'($urandom_range(0, 7));
    mem_wD = $urandom; wb_rf_we = 1'($urandom); wb_wR = 5'($urandom_range(0, 7)); wb_wD = $urandom;
  endtask

  initial begin
    clear_inputs();
    cpu_rstn = 0;
    model_bubble();
    m_cnt = 0;

    // Reset with random inputs toggling.
    @(negedge cpu_clk);
    for (int i = 0; i < 3; i++) begin
      random_inputs();
      @(posedge cpu_clk); #1;
      check_all();
      @(negedge cpu_clk);
    end

    // First capture after release.
    clear_inputs();
    cpu_rstn = 1;
    id_valid = 1; id_pc = 32'h1C000000;
    step(1);
    chk("first_pc", ex_pc, 32'h1C000000);
    chk("first_valid", ex_valid, 1);

    // EX forward beats MEM.
    clear_inputs();
    id_valid = 1; id_rf_we = 1; id_wR = 5;
    step(1);
    clear_inputs();
    id_valid = 1; id_use_r1 = 1; id_rR1 = 5; id_rD1 = 32'h11; ex_alu_c = 32'h30;
    mem_rf_we = 1; mem_wR = 5; mem_wD = 32'h99;
    step(1);
    chk("ex_fwd", ex_rD1, 32'h30);

    // Load-use: one bubble, then MEM forward of the load data.
    clear_inputs();
    id_valid = 1; id_rf_we = 1; id_wR = 7; id_is_load = 1;
    step(1);
    clear_inputs();
    id_valid = 1; id_use_r2 = 1; id_rR2 = 7; id_rD2 = 32'h1234;
    #1 chk("lu_hi", load_use_stall, 1);
    step(1);
    chk("lu_bubble", ex_valid, 0);
    chk("lu_cnt", bubble_cnt, 1);
    mem_rf_we = 1; mem_wR = 7; mem_wD = 32'hDEADBEEF;
    #1 chk("lu_lo", load_use_stall, 0);
    step(1);
    chk("lu_fwd", ex_rD2, 32'hDEADBEEF);

    // r0 never forwarded.
    clear_inputs();
    id_valid = 1; id_rR1 = 0; id_rD1 = 0; id_use_r1 = 1;
    mem_rf_we = 1; mem_wR = 0; mem_wD = 32'h5;
    step(1);
    chk("r0", ex_rD1, 0);

    // Stall dominates flush, then flush alone makes a bubble.
    clear_inputs();
    id_valid = 1; id_pc = 32'hABCD0000; id_rf_we = 1; id_wR = 3;
    step(1);
    stall = 1; flush = 1; id_pc = 32'h0BAD0000;
    for (int i = 0; i < 3; i++) step(1);
    chk("stall_pc", ex_pc, 32'hABCD0000);
    chk("stall_cnt", bubble_cnt, 1);
    stall = 0;
    step(1);
    chk("flush_cnt", bubble_cnt, 2);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      random_inputs();
      step(1);
    end

    // Asynchronous reset between clock edges.
    random_inputs();
    #2 cpu_rstn = 0;
    #1;
    model_bubble();
    m_cnt = 0;
    check_all();
    @(negedge cpu_clk);
    cpu_rstn = 1;
    for (int i = 0; i < 20; i++) begin
      random_inputs();
      step(1);
    end

    // Counter saturation.
    clear_inputs();
    flush = 1;
    for (int i = 0; i < 65537; i++) step(0);
    chk("sat", bubble_cnt, 16'hFFFF);
    step(1);
    chk("sat_hold", bubble_cnt, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
